// File: rtl/arm_bus_ctrl_if.sv
// Bus bundle between the synchronized ARM strobes, the register file and arm_bus_ctrl.
// The controller uses the slave modport; whatever drives the ARM side (or a bench) uses master.
interface arm_bus_ctrl_if #(
    parameter int unsigned ADDR_W = 24
);
    // ARM side, already synchronized into the clk domain
    logic              as;
    logic              rs_n;
    logic              ws_n;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be_n;
    logic [31:0]       din;

    // Register-file side
    logic [31:0]       rf_rdata;
    logic              irq_clr;
    logic [ADDR_W-1:0] rf_addr;
    logic [31:0]       rf_wdata;
    logic [3:0]        rf_be;
    logic              rf_wr;
    logic              rf_rd;

    // Response to the ARM
    logic [31:0]       dout;
    logic              dout_oe;
    logic              dtack_n;
    logic              irq;
    logic              busy;

    modport slave (
        input  as, rs_n, ws_n, addr, be_n, din, rf_rdata, irq_clr,
        output rf_addr, rf_wdata, rf_be, rf_wr, rf_rd, dout, dout_oe, dtack_n, irq, busy
    );

    modport master (
        output as, rs_n, ws_n, addr, be_n, din, rf_rdata, irq_clr,
        input  rf_addr, rf_wdata, rf_be, rf_wr, rf_rd, dout, dout_oe, dtack_n, irq, busy
    );
endinterface

// File: rtl/arm_bus_ctrl.sv
// ARM asynchronous-bus access controller: turns synchronized ARM strobes into single-cycle
// register-file read/write pulses, returns read data with a DTACK handshake, and aborts
// malformed or stuck accesses into an error state that raises a sticky interrupt.
module arm_bus_ctrl #(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned RD_LAT    = 2,    // legal range 1..7
    parameter int unsigned TO_CYCLES = 1023
) (
    input logic           clk,
    input logic           rst_n,
    arm_bus_ctrl_if.slave bus
);

    localparam int unsigned TO_W    = $clog2(TO_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TO_CYCLES);
    localparam logic [2:0]      LAT_MAX = 3'(RD_LAT);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRdWait = 3'd1;
    localparam logic [2:0] StWr     = 3'd2;
    localparam logic [2:0] StHold   = 3'd3;
    localparam logic [2:0] StErr    = 3'd4;

    logic [2:0]        state_q,    state_d;
    logic [2:0]        lat_cnt_q,  lat_cnt_d;
    logic [TO_W-1:0]   to_cnt_q,   to_cnt_d;
    logic [ADDR_W-1:0] rf_addr_q,  rf_addr_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;
    logic [3:0]        rf_be_q,    rf_be_d;
    logic              rf_wr_q,    rf_wr_d;
    logic              rf_rd_q,    rf_rd_d;
    logic [31:0]       dout_q,     dout_d;
    logic              dout_oe_q,  dout_oe_d;
    logic              dtack_n_q,  dtack_n_d;
    logic              irq_q,      irq_d;
    logic              busy_q,     busy_d;

    logic              irq_set;
    logic              timeout;
    logic              strobes_off;
    logic [TO_W-1:0]   to_inc;

    // Next-state, capture and handshake decode for the access FSM
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        rf_addr_d   = rf_addr_q;
        rf_wdata_d  = rf_wdata_q;
        rf_be_d     = rf_be_q;
        dout_d      = dout_q;
        dout_oe_d   = dout_oe_q;
        dtack_n_d   = dtack_n_q;
        rf_rd_d     = 1'b0;
        rf_wr_d     = 1'b0;
        irq_set     = 1'b0;

        // Saturating count of cycles spent outside IDLE
        to_inc      = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_W'(1);
        to_cnt_d    = to_inc;
        timeout     = (to_inc == TO_MAX);
        strobes_off = bus.rs_n & bus.ws_n;

        case (state_q)
            StIdle: begin
                to_cnt_d = '0;
                if (bus.as) begin
                    if (!bus.rs_n && !bus.ws_n) begin
                        // Both strobes at once is a protocol violation: no pulses, no capture
                        state_d = StErr;
                        irq_set = 1'b1;
                    end else if (!bus.rs_n) begin
                        rf_addr_d = bus.addr;
                        rf_be_d   = ~bus.be_n;
                        rf_rd_d   = 1'b1;
                        lat_cnt_d = 3'd1;
                        state_d   = StRdWait;
                    end else if (!bus.ws_n) begin
                        rf_addr_d  = bus.addr;
                        rf_wdata_d = bus.din;
                        rf_be_d    = ~bus.be_n;
                        // An all-disabled write is acknowledged but never reaches the file
                        rf_wr_d    = |(~bus.be_n);
                        state_d    = StWr;
                    end
                end
            end

            StRdWait: begin
                if (timeout) begin
                    state_d = StErr;
                    irq_set = 1'b1;
                end else if (lat_cnt_q == LAT_MAX) begin
                    dout_d    = bus.rf_rdata;
                    dout_oe_d = 1'b1;
                    dtack_n_d = 1'b0;
                    state_d   = StHold;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end

            StWr: begin
                if (timeout) begin
                    state_d = StErr;
                    irq_set = 1'b1;
                end else begin
                    dtack_n_d = 1'b0;
                    state_d   = StHold;
                end
            end

            StHold: begin
                if (timeout) begin
                    dout_oe_d = 1'b0;
                    dtack_n_d = 1'b1;
                    state_d   = StErr;
                    irq_set   = 1'b1;
                end else if (strobes_off) begin
                    dout_oe_d = 1'b0;
                    dtack_n_d = 1'b1;
                    state_d   = StIdle;
                end
            end

            StErr: begin
                dout_oe_d = 1'b0;
                dtack_n_d = 1'b1;
                if (strobes_off) begin
                    state_d = StIdle;
                end
            end

            default: begin
                dout_oe_d = 1'b0;
                dtack_n_d = 1'b1;
                state_d   = StIdle;
            end
        endcase

        // Sticky interrupt; a new error beats a coincident clear
        irq_d  = irq_set | (irq_q & ~bus.irq_clr);
        busy_d = (state_d != StIdle);
    end

    // State and registered outputs, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lat_cnt_q  <= 3'd0;
            to_cnt_q   <= '0;
            rf_addr_q  <= '0;
            rf_wdata_q <= 32'h0;
            rf_be_q    <= 4'h0;
            rf_wr_q    <= 1'b0;
            rf_rd_q    <= 1'b0;
            dout_q     <= 32'h0;
            dout_oe_q  <= 1'b0;
            dtack_n_q  <= 1'b1;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            to_cnt_q   <= to_cnt_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_be_q    <= rf_be_d;
            rf_wr_q    <= rf_wr_d;
            rf_rd_q    <= rf_rd_d;
            dout_q     <= dout_d;
            dout_oe_q  <= dout_oe_d;
            dtack_n_q  <= dtack_n_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.rf_be    = rf_be_q;
    assign bus.rf_wr    = rf_wr_q;
    assign bus.rf_rd    = rf_rd_q;
    assign bus.dout     = dout_q;
    assign bus.dout_oe  = dout_oe_q;
    assign bus.dtack_n  = dtack_n_q;
    assign bus.irq      = irq_q;
    assign bus.busy     = busy_q;

    // Handshake invariants
    a_rd_wr_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(rf_rd_q && rf_wr_q));
    a_oe_in_hold : assert property (@(posedge clk) disable iff (!rst_n)
        dout_oe_q |-> (state_q == StHold));
    a_ack_in_hold : assert property (@(posedge clk) disable iff (!rst_n)
        !dtack_n_q |-> (state_q == StHold));
    a_rd_pulse : assert property (@(posedge clk) disable iff (!rst_n)
        rf_rd_q |-> (state_q == StRdWait));
    a_wr_pulse : assert property (@(posedge clk) disable iff (!rst_n)
        rf_wr_q |-> (state_q == StWr));

endmodule

// File: tb/tb_arm_bus_ctrl.sv
// Directed bench for arm_bus_ctrl: a per-cycle vector table for read, write, empty-write and
// protocol-error traffic, plus hand-written timeout and reset-during-read sequences.
module tb_arm_bus_ctrl;

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] W1 = 32'h12345678;
    localparam logic [31:0] W2 = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    arm_bus_ctrl_if #(.ADDR_W(24)) bus ();

    arm_bus_ctrl #(
        .ADDR_W    (24),
        .RD_LAT    (2),
        .TO_CYCLES (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        as;
        logic        rs_n;
        logic        ws_n;
        logic [23:0] addr;
        logic [3:0]  be_n;
        logic [31:0] din;
        logic [31:0] rdata;
        logic        clr;
        logic [97:0] exp;
    } vec_t;

    vec_t vecs[$];

    // {rf_rd, rf_wr, dtack_n, dout_oe, irq, busy, dout, rf_addr, rf_wdata, rf_be}
    function automatic logic [97:0] pk(logic rd, logic wr, logic dt, logic oe, logic irq,
                                       logic busy, logic [31:0] dout, logic [23:0] addr,
                                       logic [31:0] wdata, logic [3:0] be);
        return {rd, wr, dt, oe, irq, busy, dout, addr, wdata, be};
    endfunction

    function automatic logic [97:0] outs();
        return pk(bus.rf_rd, bus.rf_wr, bus.dtack_n, bus.dout_oe, bus.irq, bus.busy,
                  bus.dout, bus.rf_addr, bus.rf_wdata, bus.rf_be);
    endfunction

    function automatic logic [5:0] ctrl();
        return {bus.rf_rd, bus.rf_wr, bus.dtack_n, bus.dout_oe, bus.irq, bus.busy};
    endfunction

    function automatic void add(string nm, logic a_s, logic rs, logic ws, logic [23:0] a,
                                logic [3:0] ben, logic [31:0] d, logic [31:0] rdat, logic c,
                                logic [97:0] e);
        vec_t v;
        v.name = nm; v.as = a_s; v.rs_n = rs; v.ws_n = ws; v.addr = a; v.be_n = ben;
        v.din = d; v.rdata = rdat; v.clr = c; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic drive(logic a_s, logic rs, logic ws, logic [23:0] a, logic [3:0] ben,
                         logic [31:0] d, logic [31:0] rdat, logic c);
        bus.as = a_s; bus.rs_n = rs; bus.ws_n = ws; bus.addr = a; bus.be_n = ben;
        bus.din = d; bus.rf_rdata = rdat; bus.irq_clr = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 24'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("reset_async", 128'(outs()), 128'(pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        //   name        as rs ws addr     be_n   din rdata          clr expected
        add("idle0",     0, 1, 1, 24'h00, 4'h0, 0,  0,            0, pk(0,0,1,0,0,0,0, 24'h00,0, 4'h0));
        add("rd_req",    1, 0, 1, 24'h10, 4'h0, 0,  DB,           0, pk(1,0,1,0,0,1,0, 24'h10,0, 4'hF));
        add("rd_wait",   1, 0, 1, 24'h10, 4'h0, 0,  DB,           0, pk(0,0,1,0,0,1,0, 24'h10,0, 4'hF));
        add("rd_ack",    0, 0, 1, 24'h10, 4'h0, 0,  DB,           0, pk(0,0,0,1,0,1,DB,24'h10,0, 4'hF));
        add("rd_hold",   0, 0, 1, 24'h10, 4'h0, 0,  32'hCAFEF00D, 0, pk(0,0,0,1,0,1,DB,24'h10,0, 4'hF));
        add("rd_rel",    0, 1, 1, 24'h10, 4'h0, 0,  32'hCAFEF00D, 0, pk(0,0,1,0,0,0,DB,24'h10,0, 4'hF));
        add("wr_req",    1, 1, 0, 24'h04, 4'hC, W1, 0,            0, pk(0,1,1,0,0,1,DB,24'h04,W1,4'h3));
        add("wr_ack",    1, 1, 0, 24'h04, 4'hC, W1, 0,            0, pk(0,0,0,0,0,1,DB,24'h04,W1,4'h3));
        add("wr_hold",   0, 1, 0, 24'h04, 4'hC, W1, 0,            0, pk(0,0,0,0,0,1,DB,24'h04,W1,4'h3));
        add("wr_rel",    0, 1, 1, 24'h04, 4'hC, W1, 0,            0, pk(0,0,1,0,0,0,DB,24'h04,W1,4'h3));
        add("ew_req",    1, 1, 0, 24'h08, 4'hF, W2, 0,            0, pk(0,0,1,0,0,1,DB,24'h08,W2,4'h0));
        add("ew_ack",    0, 1, 0, 24'h08, 4'hF, W2, 0,            0, pk(0,0,0,0,0,1,DB,24'h08,W2,4'h0));
        add("ew_rel",    0, 1, 1, 24'h08, 4'hF, W2, 0,            0, pk(0,0,1,0,0,0,DB,24'h08,W2,4'h0));
        add("err_req",   1, 0, 0, 24'h20, 4'h0, 0,  0,            0, pk(0,0,1,0,1,1,DB,24'h08,W2,4'h0));
        add("err_stay",  0, 0, 0, 24'h20, 4'h0, 0,  0,            0, pk(0,0,1,0,1,1,DB,24'h08,W2,4'h0));
        add("err_rel",   0, 1, 1, 24'h20, 4'h0, 0,  0,            0, pk(0,0,1,0,1,0,DB,24'h08,W2,4'h0));
        add("irq_clr",   0, 1, 1, 24'h20, 4'h0, 0,  0,            1, pk(0,0,1,0,0,0,DB,24'h08,W2,4'h0));
        add("as_low_rw", 0, 0, 0, 24'h20, 4'h0, 0,  0,            0, pk(0,0,1,0,0,0,DB,24'h08,W2,4'h0));
        add("as_low_rd", 0, 0, 1, 24'h24, 4'h0, 0,  0,            0, pk(0,0,1,0,0,0,DB,24'h08,W2,4'h0));
        add("err_clr",   1, 0, 0, 24'h20, 4'h0, 0,  0,            1, pk(0,0,1,0,1,1,DB,24'h08,W2,4'h0));
        add("err_rel2",  0, 1, 1, 24'h20, 4'h0, 0,  0,            0, pk(0,0,1,0,1,0,DB,24'h08,W2,4'h0));
        add("irq_clr2",  0, 1, 1, 24'h20, 4'h0, 0,  0,            1, pk(0,0,1,0,0,0,DB,24'h08,W2,4'h0));
        add("gap_idle",  0, 1, 1, 24'h20, 4'h0, 0,  0,            0, pk(0,0,1,0,0,0,DB,24'h08,W2,4'h0));

        foreach (vecs[i]) begin
            drive(vecs[i].as, vecs[i].rs_n, vecs[i].ws_n, vecs[i].addr, vecs[i].be_n,
                  vecs[i].din, vecs[i].rdata, vecs[i].clr);
            step();
            check(vecs[i].name, 128'(outs()), 128'(vecs[i].exp));
        end

        // Timeout: read acknowledged, strobe never released; abort when the count hits 16
        drive(1'b1, 1'b0, 1'b1, 24'h30, 4'h0, 32'h0, 32'h11112222, 1'b0);
        step();                                        // edge N
        check("to_rd_pulse", 128'(ctrl()), 128'(6'b101001));
        bus.as = 1'b0;
        step();                                        // N+1
        check("to_rd_wait", 128'(ctrl()), 128'(6'b001001));
        step();                                        // N+2
        check("to_ack", 128'(ctrl()), 128'(6'b000101));
        check("to_dout", 128'(bus.dout), 128'(32'h11112222));
        repeat (13) step();                            // N+15
        check("to_before", 128'(ctrl()), 128'(6'b000101));
        step();                                        // N+16
        check("to_abort", 128'(ctrl()), 128'(6'b001011));
        repeat (3) step();                             // N+19, strobe low for 20 edges
        check("to_err_stay", 128'(ctrl()), 128'(6'b001011));
        bus.rs_n = 1'b1;
        step();
        check("to_idle", 128'(ctrl()), 128'(6'b001010));
        bus.irq_clr = 1'b1;
        step();
        check("to_irq_clr", 128'(ctrl()), 128'(6'b001000));
        bus.irq_clr = 1'b0;

        // Reset while the read is waiting for register-file data
        drive(1'b1, 1'b0, 1'b1, 24'h40, 4'h0, 32'h0, 32'h55AA55AA, 1'b0);
        step();
        check("rst_rd_pulse", 128'(ctrl()), 128'(6'b101001));
        bus.as = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1 check("rst_mid_read", 128'(outs()), 128'(pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
        bus.rs_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rst_after_%0d", k), 128'({ctrl(), bus.dout}),
                  128'({6'b001000, 32'h0}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arm_bus_ctrl.md
ARM_BUS_CTRL -- requirements
Module: arm_bus_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 24: ARM address width.
REQ-002 SHALL have parameter RD_LAT, default 2, legal range 1..7: register-file read latency in clk cycles.
REQ-003 SHALL have parameter TO_CYCLES, default 1023: maximum cycles an access may remain open before it is aborted.
REQ-004 SHALL have ports, in this order:
  - clk  in  1  sole clock (FPGA_CLK1 domain); all logic rising-edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - as  in  1  synchronized address strobe, active high.
  - rs_n  in  1  synchronized read strobe, active low.
  - ws_n  in  1  synchronized write strobe, active low.
  - addr  in  ADDR_W  synchronized ARM address.
  - be_n  in  4  synchronized byte enables, active low.
  - din  in  32  synchronized ARM write data.
  - rf_rdata  in  32  register-file read data.
  - irq_clr  in  1  one-cycle pulse that clears irq.
  - rf_addr  out  ADDR_W  captured access address.
  - rf_wdata  out  32  captured write data.
  - rf_be  out  4  captured byte enables, active high.
  - rf_wr  out  1  one-cycle register-file write pulse.
  - rf_rd  out  1  one-cycle register-file read pulse.
  - dout  out  32  read data returned to the ARM.
  - dout_oe  out  1  ARM_D output-enable request.
  - dtack_n  out  1  access acknowledge, active low.
  - irq  out  1  sticky error interrupt.
  - busy  out  1  high whenever the state is not IDLE.

Function
REQ-005 SHALL implement the states IDLE, RD_WAIT, WR, HOLD and ERR; every output SHALL be registered.
REQ-006 In IDLE with as=1, rs_n=0 and ws_n=1 at edge N, the block SHALL capture addr into rf_addr and ~be_n into rf_be, pulse rf_rd during cycle N+1, and enter RD_WAIT.
REQ-007 In IDLE with as=1, ws_n=0 and rs_n=1 at edge N, the block SHALL capture addr, din and ~be_n, then enter WR.
REQ-008 In IDLE with as=1 and both rs_n=0 and ws_n=0, the block SHALL enter ERR and set irq, with no rf_rd or rf_wr pulse.
REQ-009 In IDLE, as=0 SHALL be ignored regardless of the strobes.
REQ-010 RD_WAIT SHALL count RD_LAT cycles starting from the rf_rd cycle; on the final count it SHALL load rf_rdata into dout, set dout_oe=1 and dtack_n=0, and enter HOLD.
  - Consequence: read data is valid and acknowledged from cycle N+RD_LAT+1.
REQ-011 WR SHALL pulse rf_wr for exactly one cycle (N+1), set dtack_n=0 from N+2, and enter HOLD.
REQ-012 If captured rf_be is 4'b0000, WR SHALL suppress rf_wr but still acknowledge.
REQ-013 HOLD SHALL keep dtack_n=0, dout and dout_oe stable until rs_n=1 and ws_n=1 are both sampled.
  - On that edge: dout_oe=1 to 0, dtack_n=0 to 1, state to IDLE.
REQ-014 A new access SHALL NOT be accepted in the same cycle the block returns to IDLE (minimum one idle cycle between accesses).
REQ-015 A timeout counter SHALL clear on leaving IDLE and increment every non-IDLE cycle, saturating at TO_CYCLES.
REQ-016 Reaching TO_CYCLES in RD_WAIT, WR or HOLD SHALL force ERR and set irq.
REQ-017 ERR SHALL hold dout_oe=0, dtack_n=1, rf_rd=0 and rf_wr=0, and return to IDLE once rs_n=1 and ws_n=1 are both sampled.
REQ-018 irq SHALL stay set until an irq_clr pulse; if set and clear coincide, set SHALL win.
REQ-019 rf_rd and rf_wr SHALL never be high together.
REQ-020 dout_oe SHALL never be high outside HOLD.

Reset
REQ-021 While rst_n=0, the block SHALL assert immediately, with no clock required:
  - state IDLE;
  - rf_wr, rf_rd, dout_oe, irq and busy all 0;
  - dtack_n=1;
  - rf_addr, rf_wdata, rf_be and dout all 0;
  - timeout counter 0.
REQ-022 Reset asserted mid-access SHALL abort the access with no further rf_wr or rf_rd pulse after deassertion.
REQ-023 Release of reset SHALL take effect on the first clk edge after rst_n rises.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
  - Read, RD_LAT=2: as=1, rs_n=0, addr=0x000010, be_n=0, rf_rdata=0xDEADBEEF -> rf_rd pulse at N+1; dout=0xDEADBEEF, dout_oe=1, dtack_n=0 at N+3; released one cycle after rs_n=1.
  - Write: ws_n=0, addr=0x000004, din=0x12345678, be_n=4'b1100 -> single rf_wr at N+1 with rf_be=4'b0011 and rf_wdata=0x12345678; dtack_n=0 at N+2.
  - Empty write: be_n=4'b1111 -> no rf_wr; dtack_n still 0 at N+2.
  - Protocol error: rs_n=0 and ws_n=0 together -> ERR, irq=1, no pulses.
    - Then irq_clr pulse -> irq=0.
    - Then irq_clr coincident with a new error -> irq stays 1.
  - Timeout, TO_CYCLES=16: rs_n held low 20 cycles -> dtack_n=1, dout_oe=0 and irq=1 once the counter reaches 16; IDLE after rs_n=1.
  - Reset mid-read in RD_WAIT -> outputs at reset values asynchronously; no rf_rd after rst_n rises.
